// File: rtl/pc_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB control FSM that owns the PC register's next-value input.
// The PC register has no enable, so every cycle without a PC update drives pc_cur back out.
module pc_sequencer #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter logic [5:0]  HALT_OP    = 6'b111111
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] pc_cur,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [31:0] pc_next,
  output logic        pc_write,
  output logic        ir_write,
  output logic [31:0] ir,
  output logic        mem_req,
  output logic        reg_write,
  output logic        exc,
  output logic        halted,
  output logic [2:0]  state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;

  logic [5:0]  opcode, funct;
  logic        is_branch, is_mem, is_alu_imm, branch_taken;
  logic [31:0] branch_target, jump_target;

  assign opcode     = ir_q[31:26];
  assign funct      = ir_q[5:0];
  assign is_branch  = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_mem     = (opcode == OP_LW) || (opcode == OP_SW);
  assign is_alu_imm = (opcode[5:3] == 3'b001);

  // pc_cur already points past the instruction once IF has completed.
  assign branch_taken  = (opcode == OP_BEQ) ? zero : !zero;
  assign branch_target = pc_cur + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign jump_target   = {pc_cur[31:28], ir_q[25:0], 2'b00};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    ir_d      = ir_q;
    pc_next   = pc_cur;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_req   = 1'b0;
    reg_write = 1'b0;
    exc       = 1'b0;
    halted    = 1'b0;

    case (state_q)
      ST_IF: begin
        ir_write = 1'b1;
        ir_d     = instr;
        pc_write = 1'b1;
        pc_next  = pc_cur + 32'd4;
        state_d  = ST_ID;
      end
      ST_ID: begin
        if (opcode == HALT_OP) begin
          state_d = ST_HALT;
        end else if (opcode == OP_J || opcode == OP_JAL) begin
          pc_write = 1'b1;
          pc_next  = jump_target;
          state_d  = (opcode == OP_JAL) ? ST_WB : ST_IF;
        end else if (opcode == OP_RTYPE && funct == FN_JR) begin
          pc_write = 1'b1;
          pc_next  = rs_data;
          state_d  = ST_IF;
        end else if (opcode == OP_RTYPE || is_branch || is_mem || is_alu_imm) begin
          state_d = ST_EX;
        end else begin
          exc      = 1'b1;
          pc_write = 1'b1;
          pc_next  = EXC_VECTOR;
          state_d  = ST_IF;
        end
      end
      ST_EX: begin
        if (is_branch) begin
          if (branch_taken) begin
            pc_write = 1'b1;
            pc_next  = branch_target;
          end
          state_d = ST_IF;
        end else if (is_mem) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        if (mem_ready) state_d = (opcode == OP_LW) ? ST_WB : ST_IF;
      end
      ST_WB: begin
        reg_write = 1'b1;
        state_d   = ST_IF;
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_IF;
    endcase

    // Reset abandons the instruction at once, without waiting for a clock edge.
    if (!RST) begin
      pc_next   = pc_cur;
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_req   = 1'b0;
      reg_write = 1'b0;
      exc       = 1'b0;
      halted    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IF;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  assign ir    = ir_q;
  assign state = state_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle control FSM that owns the program counter register's next-value input.
- Latches the fetched instruction and steps it through IF/ID/EX/MEM/WB.
- Computes the next PC (sequential, branch, jump, jump-register, exception vector). When the PC must not advance, it drives the current PC back so the enable-less PC register holds.
- Sits between instruction memory, the ALU zero flag, the data-memory handshake and the PC register.

Parameters:
- EXC_VECTOR, 32'h0000_0080, PC loaded on an undefined opcode.
- HALT_OP, 6'b111111, opcode that parks the core.

Ports:
- clk  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset (RST==0 resets).
- pc_cur  input  32  current PC register output.
- instr  input  32  instruction-memory read data at pc_cur.
- rs_data  input  32  register-file rs read value (jr target).
- zero  input  1  ALU zero flag, valid in EX.
- mem_ready  input  1  data memory completes the access this cycle.
- pc_next  output  32  PC register next value.
- pc_write  output  1  high when pc_next differs from the hold value.
- ir_write  output  1  instruction latched this cycle.
- ir  output  32  latched instruction.
- mem_req  output  1  data memory access request.
- reg_write  output  1  register-file write strobe.
- exc  output  1  one-cycle pulse on an undefined opcode.
- halted  output  1  core parked.
- state  output  3  IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.

Behaviour:
- Registered state: state and ir. All other outputs are combinational from state, ir, inputs and pc_cur.
- When pc_write=0, pc_next=pc_cur always.
- Reset (RST low, asynchronous):
  - state=IF, ir=0.
  - While RST is low: pc_write=ir_write=mem_req=reg_write=exc=0, pc_next=pc_cur.
- IF:
  - ir_write=1, ir<=instr at the clock edge.
  - pc_write=1, pc_next=pc_cur+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - Next state ID.
- ID (decodes ir[31:26] and ir[5:0]):
  - HALT_OP -> HALT.
  - j (000010): pc_next={pc_cur[31:28],ir[25:0],2'b00}, pc_write=1 -> IF.
  - jal (000011): same PC update -> WB (link write).
  - R-type with funct 001000 (jr): pc_next=rs_data, pc_write=1 -> IF.
  - R-type other, beq(000100), bne(000101), lw(100011), sw(101011), addi/addiu/andi/ori/xori/slti/lui (001xxx) -> EX.
  - Any other opcode: exc=1, pc_write=1, pc_next=EXC_VECTOR -> IF.
- EX:
  - beq taken when zero=1; bne taken when zero=0.
  - Taken: pc_write=1, pc_next=pc_cur+(sign_ext(ir[15:0])<<2) -> IF.
  - Not taken: -> IF with no PC write.
  - lw/sw -> MEM.
  - ALU ops -> WB.
- MEM:
  - mem_req=1 held every cycle until mem_ready=1.
  - sw + mem_ready -> IF; lw + mem_ready -> WB.
  - mem_ready=0 stays in MEM with pc_write=0.
- WB: reg_write=1 for exactly one cycle -> IF.
- HALT: halted=1, all enables 0, PC held; exits only via reset.
- Latencies with mem_ready already high:
  - ALU op 4 cycles, lw 5, sw 4, branch 3, j/jr 2, jal 3, undefined 2.
  - Each MEM wait cycle adds 1.
- mem_ready outside MEM is ignored.
- zero outside EX is ignored.
- Reset asserted mid-instruction abandons it immediately: no reg_write or mem_req pulse completes.
- Branch target arithmetic is 32-bit wrap-around. Offset -1 from pc_cur=4 gives 0.

Test Plan:
- Reset released, instr=32'h2008_0005 (addi), pc_cur follows pc_next -> states IF,ID,EX,WB; pc_next=4 in IF; reg_write only in WB; back to IF at cycle 5.
- beq at PC 0x10 with ir[15:0]=16'hFFFC, zero=1 -> in EX pc_next=0x14+(-16)=0x04, pc_write=1. Repeat with zero=0 -> no PC write, next fetch at 0x14.
- lw with mem_ready low for 3 cycles -> mem_req high 4 cycles, PC held at pc_cur, WB follows; total 8 cycles.
- jal ir[25:0]=26'h0000100 at pc_cur=0x4000_0004 -> pc_next=0x4000_0400 in ID, then WB reg_write=1. jr with rs_data=0x0000_0200 -> pc_next=0x200.
- Opcode 6'b010001 -> exc pulses 1 cycle in ID, pc_next=0x80. Opcode HALT_OP -> state 5, halted=1, pc_next=pc_cur for 20 cycles.
- Drive RST low during MEM (mem_req=1) -> mem_req drops in the same cycle without waiting for a clock edge; state=IF, ir=0; after release, fetch restarts.
